// File: rtl/ext_mem_bridge_if.sv
// Bundles the CPU request bus and the multiplexed pad bus for ext_mem_bridge.
// The slave modport is the bridge. The master modport is its environment: the CPU side plus the pads.
interface ext_mem_bridge_if;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        cpu_busy;
  logic        bus_err;
  logic [7:0]  pad_ctrl;
  logic [7:0]  pad_io_out;
  logic [7:0]  pad_io_oe;
  logic [7:0]  pad_io_in;
  logic        pad_wait;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata, pad_io_in, pad_wait,
    output cpu_rdata, cpu_ready, cpu_busy, bus_err, pad_ctrl, pad_io_out, pad_io_oe
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdata, pad_io_in, pad_wait,
    input  cpu_rdata, cpu_ready, cpu_busy, bus_err, pad_ctrl, pad_io_out, pad_io_oe
  );
endinterface

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: carries the CPU's 11-bit address / 8-bit data memory bus onto a
// multiplexed pad bus. Each transaction has an ADDR phase (ALE) and a DATA phase, followed
// by one turnaround cycle.
// Optional feature: define EXT_WAIT_EN so that pad_wait can stretch the DATA phase, up to
// WAIT_TIMEOUT extra cycles. When the limit is reached, the DATA phase ends and sticky
// bus_err is set. Without EXT_WAIT_EN, pad_wait is ignored and bus_err is tied low.
//
// state | meaning
// IDLE  | pads quiet, waiting for cpu_req
// ADDR  | one cycle: ALE high, address on pads, pads driven
// DATA  | WAIT_STATES+1 cycles (+ wait extension): read strobes OE_n, write drives data + WE_n
// RECOV | one cycle: pads released for turnaround, cpu_ready pulse
module ext_mem_bridge #(
  parameter int WAIT_STATES  = 1,
  parameter int WAIT_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  ext_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RECOV} state_t;

  // pad_ctrl with ALE=0, WE_n=1, OE_n=1 and address high bits zero
  localparam logic [7:0] CTRL_QUIET = 8'b0110_0000;

  state_t      state;
  logic        rnw_q;
  logic [10:0] addr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  cnt;
  logic        data_done;

`ifdef EXT_WAIT_EN
  logic [3:0]  ext_cnt;

  // DATA ends on the last nominal cycle unless the device stretches it and extension budget remains
  always_comb begin
    data_done = 1'b0;
    if (state == DATA && cnt == 4'd0)
      data_done = !(bus.pad_wait && ext_cnt != 4'd0);
  end
`else
  logic unused_wait;
  assign unused_wait = bus.pad_wait;
  assign bus.bus_err = 1'b0;

  // DATA ends once the wait-state counter reaches terminal count
  always_comb begin
    data_done = 1'b0;
    if (state == DATA && cnt == 4'd0)
      data_done = 1'b1;
  end
`endif

  // Transaction sequencer; all pad and CPU-side outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rnw_q          <= 1'b1;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt            <= '0;
      bus.pad_ctrl   <= CTRL_QUIET;
      bus.pad_io_out <= '0;
      bus.pad_io_oe  <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_busy   <= 1'b0;
`ifdef EXT_WAIT_EN
      ext_cnt        <= '0;
      bus.bus_err    <= 1'b0;
`endif
    end else begin
      bus.cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            rnw_q          <= bus.cpu_rnw;
            addr_q         <= bus.cpu_addr;
            wdata_q        <= bus.cpu_wdata;
            bus.cpu_busy   <= 1'b1;
            bus.pad_ctrl   <= {3'b111, 2'b00, bus.cpu_addr[10:8]};
            bus.pad_io_out <= bus.cpu_addr[7:0];
            bus.pad_io_oe  <= 8'hFF;
`ifdef EXT_WAIT_EN
            bus.bus_err    <= 1'b0;
`endif
            state          <= ADDR;
          end
        end
        ADDR: begin
          cnt <= 4'(WAIT_STATES);
`ifdef EXT_WAIT_EN
          ext_cnt <= 4'(WAIT_TIMEOUT);
`endif
          // WE_n low only for writes, OE_n low only for reads; reads never drive the pads
          bus.pad_ctrl   <= {1'b0, rnw_q, ~rnw_q, 2'b00, addr_q[10:8]};
          bus.pad_io_out <= rnw_q ? 8'h00 : wdata_q;
          bus.pad_io_oe  <= rnw_q ? 8'h00 : 8'hFF;
          state          <= DATA;
        end
        DATA: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (data_done) begin
            if (rnw_q)
              bus.cpu_rdata <= bus.pad_io_in;
`ifdef EXT_WAIT_EN
            // still waiting with no budget left: give up and flag it
            if (bus.pad_wait)
              bus.bus_err <= 1'b1;
`endif
            bus.cpu_ready  <= 1'b1;
            bus.pad_ctrl   <= CTRL_QUIET;
            bus.pad_io_out <= 8'h00;
            bus.pad_io_oe  <= 8'h00;
            state          <= RECOV;
          end else begin
`ifdef EXT_WAIT_EN
            ext_cnt <= ext_cnt - 4'd1;
`endif
          end
        end
        RECOV: begin
          bus.cpu_busy <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Testbench for ext_mem_bridge. It runs directed vector-table transactions, then hand-written
// sequences for back-to-back requests, reset in the middle of a transaction and (with
// EXT_WAIT_EN) wait stretching. It finishes with randomized transactions.
// Expected behaviour comes from a transaction-level model: the phase lengths, the pad
// encodings and the rdata/bus_err bookkeeping.
module tb_ext_mem_bridge;
  localparam int WS = 1;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_mem_bridge_if bus();

  ext_mem_bridge #(.WAIT_STATES(WS), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] model_rdata;
  logic       model_err;

  typedef struct {
    bit          rnw;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  io_in;
    logic [7:0]  exp_addr_ctrl;
    logic [7:0]  exp_data_ctrl;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] ac, dc, rd;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  // Quiet bus checks, one per idle cycle; req held low.
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check1("idle_busy", bus.cpu_busy, 1'b0);
      check1("idle_ready", bus.cpu_ready, 1'b0);
      check8("idle_oe", bus.pad_io_oe, 8'h00);
      check8("idle_strobes", {5'b0, bus.pad_ctrl[7:5]}, 8'h03);
      check8("idle_rdata", bus.cpu_rdata, model_rdata);
    end
  endtask

  // One full transaction. The call starts away from a clock edge with the DUT idle and returns
  // at the negedge of the IDLE cycle that follows RECOV. With hold=1, req stays high so that a
  // following call is accepted at the very next edge.
  task automatic do_txn(input bit rnw, input logic [10:0] addr, input logic [7:0] wdata,
                        input logic [7:0] io_in, input int nwait, input bit hold,
                        output logic [7:0] addr_ctrl, output logic [7:0] data_ctrl,
                        output logic [7:0] rd_at_ready);
    int         len;
    bit         err;
    logic [7:0] exp_dctrl;
    len = WS + 1;
    err = 1'b0;
`ifdef EXT_WAIT_EN
    if (nwait > TO) begin
      len += TO;
      err = 1'b1;
    end else begin
      len += nwait;
    end
`endif
    exp_dctrl = {1'b0, rnw, ~rnw, 2'b00, addr[10:8]};
    data_ctrl = 8'h00;

    bus.cpu_req   = 1'b1;
    bus.cpu_rnw   = rnw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk); #1;
    bus.cpu_req = hold;
    model_err   = 1'b0;
    if (!hold) begin
      bus.cpu_rnw   = ~rnw;
      bus.cpu_addr  = 11'($urandom);
      bus.cpu_wdata = 8'($urandom);
    end
    @(negedge clk);
    addr_ctrl = bus.pad_ctrl;
    check8("addr_ctrl", bus.pad_ctrl, {3'b111, 2'b00, addr[10:8]});
    check8("addr_io_out", bus.pad_io_out, addr[7:0]);
    check8("addr_oe", bus.pad_io_oe, 8'hFF);
    check1("addr_busy", bus.cpu_busy, 1'b1);
    check1("addr_ready", bus.cpu_ready, 1'b0);
    check1("addr_err", bus.bus_err, 1'b0);

    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      bus.pad_wait  = (k >= WS) && (k < WS + nwait);
      bus.pad_io_in = (k == len - 1) ? io_in : 8'($urandom);
      if (!hold) bus.cpu_req = 1'($urandom);
      @(negedge clk);
      if (k == 0) data_ctrl = bus.pad_ctrl;
      check8("data_ctrl", bus.pad_ctrl, exp_dctrl);
      check8("data_oe", bus.pad_io_oe, rnw ? 8'h00 : 8'hFF);
      if (!rnw) check8("data_io_out", bus.pad_io_out, wdata);
      check1("data_ready", bus.cpu_ready, 1'b0);
      check1("data_busy", bus.cpu_busy, 1'b1);
    end

    @(posedge clk); #1;
    bus.cpu_req   = hold;
    bus.pad_wait  = 1'b0;
    bus.pad_io_in = 8'($urandom);
    if (rnw) model_rdata = io_in;
    model_err = err;
    @(negedge clk);
    rd_at_ready = bus.cpu_rdata;
    check1("recov_ready", bus.cpu_ready, 1'b1);
    check1("recov_busy", bus.cpu_busy, 1'b1);
    check8("recov_oe", bus.pad_io_oe, 8'h00);
    check8("recov_strobes", {5'b0, bus.pad_ctrl[7:5]}, 8'h03);
    check8("recov_rdata", bus.cpu_rdata, model_rdata);
    check1("recov_err", bus.bus_err, model_err);

    @(posedge clk); #1;
    @(negedge clk);
    check1("post_ready", bus.cpu_ready, 1'b0);
    check1("post_busy", bus.cpu_busy, 1'b0);
    check8("post_oe", bus.pad_io_oe, 8'h00);
    check8("post_rdata", bus.cpu_rdata, model_rdata);
    check1("post_err", bus.bus_err, model_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 11'h5A3, 8'h00, 8'hC7, 8'hE5, 8'h45, 8'hC7};
    vecs[1] = '{1'b0, 11'h100, 8'h3C, 8'h00, 8'hE1, 8'h21, 8'hC7};
    vecs[2] = '{1'b1, 11'h7FF, 8'h00, 8'h00, 8'hE7, 8'h47, 8'h00};
    vecs[3] = '{1'b0, 11'h0FF, 8'hA5, 8'h11, 8'hE0, 8'h20, 8'h00};
    vecs[4] = '{1'b1, 11'h000, 8'h00, 8'hFF, 8'hE0, 8'h40, 8'hFF};

    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_rnw   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.pad_io_in = '0;
    bus.pad_wait  = 1'b0;
    model_rdata   = 8'h00;
    model_err     = 1'b0;

    // reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check8("rst_ctrl", bus.pad_ctrl, 8'h60);
    check8("rst_oe", bus.pad_io_oe, 8'h00);
    check8("rst_io_out", bus.pad_io_out, 8'h00);
    check1("rst_ready", bus.cpu_ready, 1'b0);
    check1("rst_busy", bus.cpu_busy, 1'b0);
    check8("rst_rdata", bus.cpu_rdata, 8'h00);
    check1("rst_err", bus.bus_err, 1'b0);
    rst = 1'b0;
    idle_cycles(2);

    // directed vector table
    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].io_in, 0, 1'b0, ac, dc, rd);
      check8("vec_addr_ctrl", ac, vecs[i].exp_addr_ctrl);
      check8("vec_data_ctrl", dc, vecs[i].exp_data_ctrl);
      check8("vec_rdata", rd, vecs[i].exp_rdata);
      idle_cycles(1);
    end

    // back-to-back: read with req held high, then write accepted right after the IDLE cycle
    do_txn(1'b1, 11'h2AB, 8'h00, 8'h5E, 0, 1'b1, ac, dc, rd);
    do_txn(1'b0, 11'h455, 8'h99, 8'h00, 0, 1'b0, ac, dc, rd);
    check8("b2b_ale_ctrl", ac, 8'hE4);
    check8("b2b_rdata_kept", rd, 8'h5E);
    idle_cycles(1);

    // reset during the DATA phase of a write
    bus.cpu_req   = 1'b1;
    bus.cpu_rnw   = 1'b0;
    bus.cpu_addr  = 11'h123;
    bus.cpu_wdata = 8'h77;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check8("mid_data_ctrl", bus.pad_ctrl, 8'h21);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 8'h00;
    @(negedge clk);
    check8("mid_rst_ctrl", bus.pad_ctrl, 8'h60);
    check8("mid_rst_oe", bus.pad_io_oe, 8'h00);
    check1("mid_rst_ready", bus.cpu_ready, 1'b0);
    check1("mid_rst_busy", bus.cpu_busy, 1'b0);
    check8("mid_rst_rdata", bus.cpu_rdata, 8'h00);
    idle_cycles(4);
    do_txn(1'b1, 11'h3C0, 8'h00, 8'hB4, 0, 1'b0, ac, dc, rd);
    check8("after_rst_rdata", rd, 8'hB4);
    idle_cycles(1);

`ifdef EXT_WAIT_EN
    // pad_wait for 3 cycles stretches DATA by 3; stuck wait runs into the timeout
    do_txn(1'b1, 11'h0A0, 8'h00, 8'h6D, 3, 1'b0, ac, dc, rd);
    check8("wait3_rdata", rd, 8'h6D);
    do_txn(1'b1, 11'h0A1, 8'h00, 8'h2F, 1000, 1'b0, ac, dc, rd);
    check8("timeout_rdata", rd, 8'h2F);
    check1("timeout_err_sticky", bus.bus_err, 1'b1);
    idle_cycles(2);
    do_txn(1'b0, 11'h0A2, 8'h5A, 8'h00, 0, 1'b0, ac, dc, rd);
    idle_cycles(1);
`endif

    // randomized transactions against the model
    for (int n = 0; n < 60; n++) begin
      bit          r_rnw;
      bit          r_hold;
      int          r_wait;
      r_rnw  = 1'($urandom);
      r_hold = (n < 59) ? 1'($urandom) : 1'b0;
      r_wait = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO + 1, TO + 4))
                                           : int'($urandom_range(0, 3));
      do_txn(r_rnw, 11'($urandom), 8'($urandom), 8'($urandom), r_wait, r_hold, ac, dc, rd);
      if (!r_hold && $urandom_range(0, 1) == 1)
        idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
